// File: rtl/pipe_front.sv
// pipe_front: fetch and decode front end of a five-stage RISC-V style pipeline.
// Holds the PC register, the IF/ID and ID/EX pipeline registers, the
// execute-stage operand forwarding muxes and two saturating hazard event
// counters.
//
// Ports
//   clk, reset_n                : rising-edge clock, synchronous active-low reset
//   StallF, StallD              : hold the PC / the IF/ID register
//   FlushD, FlushE              : squash IF/ID to a NOP / ID/EX to a bubble
//   ForwardAE, ForwardBE        : operand forwarding selects for E
//   PCSrcE, PCTargetE           : redirect request and target from E
//   InstrF                      : instruction fetched at PCF
//   RD1D, RD2D, ImmExtD, CtrlD  : decode-stage operands, immediate, control bundle
//   ALUResultM, ResultW         : forwarding sources from M and W
//   PCF                         : fetch PC
//   InstrD, PCD, PCPlus4D       : IF/ID register contents
//   Rs1D, Rs2D                  : source register fields of InstrD
//   PCE, ImmExtE, Rs1E, Rs2E,
//   RdE, CtrlE                  : ID/EX register contents
//   SrcAE, WriteDataE           : forwarded execute-stage operands
//   StallCount, FlushCount      : saturating stall / flush event counters

module pipe_front (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmExtD,
    input  logic [11:0] CtrlD,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [31:0] PCE,
    output logic [31:0] ImmExtE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [11:0] CtrlE,
    output logic [31:0] SrcAE,
    output logic [31:0] WriteDataE,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pcf_q,      pcf_d;
    logic [31:0] instrd_q,   instrd_d;
    logic [31:0] pcd_q,      pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;

    logic [31:0] pce_q,      pce_d;
    logic [31:0] immexte_q,  immexte_d;
    logic [4:0]  rs1e_q,     rs1e_d;
    logic [4:0]  rs2e_q,     rs2e_d;
    logic [4:0]  rde_q,      rde_d;
    logic [11:0] ctrle_q,    ctrle_d;
    logic [31:0] rd1e_q,     rd1e_d;
    logic [31:0] rd2e_q,     rd2e_d;

    logic [15:0] stallcnt_q, stallcnt_d;
    logic [15:0] flushcnt_q, flushcnt_d;

    logic [31:0] pcplus4f;
    logic [4:0]  rs1d;
    logic [4:0]  rs2d;

    assign pcplus4f = pcf_q + 32'd4;
    assign rs1d     = instrd_q[19:15];
    assign rs2d     = instrd_q[24:20];

    // ------------------------------------------------------------------
    // Fetch: a redirect from E always loads, even over a fetch stall
    // ------------------------------------------------------------------
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if (!StallF) begin
            pcf_d = pcplus4f;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID: flush beats stall beats load
    // ------------------------------------------------------------------
    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        if (FlushD) begin
            instrd_d   = NOP_INSTR;
            pcd_d      = '0;
            pcplus4d_d = '0;
        end else if (!StallD) begin
            instrd_d   = InstrF;
            pcd_d      = pcf_q;
            pcplus4d_d = pcplus4f;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX: no stall; a flush inserts an all-zero bubble
    // ------------------------------------------------------------------
    always_comb begin
        pce_d     = pcd_q;
        immexte_d = ImmExtD;
        rs1e_d    = rs1d;
        rs2e_d    = rs2d;
        rde_d     = instrd_q[11:7];
        ctrle_d   = CtrlD;
        rd1e_d    = RD1D;
        rd2e_d    = RD2D;
        if (FlushE) begin
            pce_d     = '0;
            immexte_d = '0;
            rs1e_d    = '0;
            rs2e_d    = '0;
            rde_d     = '0;
            ctrle_d   = '0;
            rd1e_d    = '0;
            rd2e_d    = '0;
        end
    end

    // ------------------------------------------------------------------
    // Event counters: one flush count per cycle even when both flushes fire
    // ------------------------------------------------------------------
    always_comb begin
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        if (StallD && (stallcnt_q != '1)) begin
            stallcnt_d = stallcnt_q + 16'd1;
        end
        if ((FlushD || FlushE) && (flushcnt_q != '1)) begin
            flushcnt_d = flushcnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers: reset overrides every control input, including PCSrcE
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcf_q      <= '0;
            instrd_q   <= NOP_INSTR;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            pce_q      <= '0;
            immexte_q  <= '0;
            rs1e_q     <= '0;
            rs2e_q     <= '0;
            rde_q      <= '0;
            ctrle_q    <= '0;
            rd1e_q     <= '0;
            rd2e_q     <= '0;
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            pcf_q      <= pcf_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            pce_q      <= pce_d;
            immexte_q  <= immexte_d;
            rs1e_q     <= rs1e_d;
            rs2e_q     <= rs2e_d;
            rde_q      <= rde_d;
            ctrle_q    <= ctrle_d;
            rd1e_q     <= rd1e_d;
            rd2e_q     <= rd2e_d;
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding muxes; the reserved select falls back to the register file
    // ------------------------------------------------------------------
    always_comb begin
        SrcAE = rd1e_q;
        case (fwd_sel_e'(ForwardAE))
            FWD_WB:   SrcAE = ResultW;
            FWD_MEM:  SrcAE = ALUResultM;
            FWD_RF,
            FWD_RSVD: SrcAE = rd1e_q;
            default:  SrcAE = rd1e_q;
        endcase
    end

    always_comb begin
        WriteDataE = rd2e_q;
        case (fwd_sel_e'(ForwardBE))
            FWD_WB:   WriteDataE = ResultW;
            FWD_MEM:  WriteDataE = ALUResultM;
            FWD_RF,
            FWD_RSVD: WriteDataE = rd2e_q;
            default:  WriteDataE = rd2e_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PCF        = pcf_q;
    assign InstrD     = instrd_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcplus4d_q;
    assign Rs1D       = rs1d;
    assign Rs2D       = rs2d;
    assign PCE        = pce_q;
    assign ImmExtE    = immexte_q;
    assign Rs1E       = rs1e_q;
    assign Rs2E       = rs2e_q;
    assign RdE        = rde_q;
    assign CtrlE      = ctrle_q;
    assign StallCount = stallcnt_q;
    assign FlushCount = flushcnt_q;

endmodule

// File: tb/tb_pipe_front.sv
// tb_pipe_front: self-checking bench for pipe_front. A table of per-cycle
// stimulus records with hand-derived expected register contents is applied
// in order; each record's expectation is queued when it is driven and
// compared after the clock edge. Forwarding muxes, counter saturation and
// reset during a redirecting stall are covered by short directed sequences.

module tb_pipe_front;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, InstrF, RD1D, RD2D, ImmExtD;
    logic [11:0] CtrlD;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D;
    logic [31:0] PCE, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [11:0] CtrlE;
    logic [31:0] SrcAE, WriteDataE;
    logic [15:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    pipe_front dut (
        .clk(clk), .reset_n(reset_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .CtrlD(CtrlD),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .PCE(PCE), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .CtrlE(CtrlE), .SrcAE(SrcAE), .WriteDataE(WriteDataE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0010_0093;   // rd=1 rs1=0 rs2=1
    localparam logic [31:0] I1  = 32'h0020_0113;   // rd=2 rs1=0 rs2=2
    localparam logic [31:0] I2  = 32'h0030_0193;   // rd=3 rs1=0 rs2=3
    localparam logic [31:0] I3  = 32'h0040_0213;   // rd=4 rs1=0 rs2=4

    typedef struct {
        logic        stf, std, fd, fe, pcs;
        logic [31:0] tgt, instrf;
        logic [11:0] ctrld;
        logic [31:0] pcf, instrd, pcd, pcp4;
        logic [11:0] ctrle;
        logic [4:0]  rde;
        logic [15:0] sc, fc;
    } vec_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [31:0] alum, resw, expa, expb;
    } fwd_t;

    vec_t        vecs[13];
    vec_t        sbq[$];
    fwd_t        fwds[6];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic stf, input logic std, input logic fd, input logic fe, input logic pcs,
        input logic [31:0] tgt, input logic [31:0] instrf, input logic [11:0] ctrld,
        input logic [31:0] pcf, input logic [31:0] instrd, input logic [31:0] pcd,
        input logic [31:0] pcp4, input logic [11:0] ctrle, input logic [4:0] rde,
        input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.stf = stf; v.std = std; v.fd = fd; v.fe = fe; v.pcs = pcs;
        v.tgt = tgt; v.instrf = instrf; v.ctrld = ctrld;
        v.pcf = pcf; v.instrd = instrd; v.pcd = pcd; v.pcp4 = pcp4;
        v.ctrle = ctrle; v.rde = rde; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic idle();
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cold(input string tag);
        chk({tag, "_PCF"},      PCF, 32'h0);
        chk({tag, "_InstrD"},   InstrD, NOP);
        chk({tag, "_PCD"},      PCD, 32'h0);
        chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
        chk({tag, "_Rs1D"},     {27'd0, Rs1D}, 32'h0);
        chk({tag, "_Rs2D"},     {27'd0, Rs2D}, 32'h0);
        chk({tag, "_PCE"},      PCE, 32'h0);
        chk({tag, "_ImmExtE"},  ImmExtE, 32'h0);
        chk({tag, "_Rs1E"},     {27'd0, Rs1E}, 32'h0);
        chk({tag, "_Rs2E"},     {27'd0, Rs2E}, 32'h0);
        chk({tag, "_RdE"},      {27'd0, RdE}, 32'h0);
        chk({tag, "_CtrlE"},    {20'd0, CtrlE}, 32'h0);
        chk({tag, "_SrcAE"},    SrcAE, 32'h0);
        chk({tag, "_WrDataE"},  WriteDataE, 32'h0);
        chk({tag, "_StallCnt"}, {16'd0, StallCount}, 32'h0);
        chk({tag, "_FlushCnt"}, {16'd0, FlushCount}, 32'h0);
    endtask

    initial begin
        vec_t exp_v;
        idle();
        InstrF = 32'hFFFF_FFFF; RD1D = '0; RD2D = '0; ImmExtD = '0; CtrlD = 12'hFFF;
        ALUResultM = '0; ResultW = '0;

        // Cold reset with every hazard control asserted, including a redirect
        reset_n = 1'b0;
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b1;
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        tick();
        tick();
        chk_cold("rst");
        reset_n = 1'b1;
        idle();

        //           stf  std  fd   fe   pcs  tgt            instrf       ctrld    pcf            instrd pcd            pcp4           ctrle    rde   sc     fc
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I0,          12'h101, 32'h4,         I0,  32'h0,         32'h4,         12'h101, 5'd0, 16'd0, 16'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I1,          12'h102, 32'h8,         I1,  32'h4,         32'h8,         12'h102, 5'd1, 16'd0, 16'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I2,          12'h103, 32'hC,         I2,  32'h8,         32'hC,         12'h103, 5'd2, 16'd0, 16'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I3,          12'h104, 32'h10,        I3,  32'hC,         32'h10,        12'h104, 5'd3, 16'd0, 16'd0);
        // load-use: F and D hold, E bubble
        vecs[4]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,32'h0,        32'hDEADBEEF,12'h105, 32'h10,        I3,  32'hC,         32'h10,        12'h000, 5'd0, 16'd1, 16'd1);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I0,          12'h106, 32'h14,        I0,  32'h10,        32'h14,        12'h106, 5'd4, 16'd1, 16'd1);
        // redirect over StallF with both flushes: one flush count
        vecs[6]  = mk(1'b1,1'b0,1'b1,1'b1,1'b1,32'h100,      I1,          12'h107, 32'h100,       NOP, 32'h0,         32'h0,         12'h000, 5'd0, 16'd1, 16'd2);
        // FlushD beats StallD
        vecs[7]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        I2,          12'h108, 32'h104,       NOP, 32'h0,         32'h0,         12'h108, 5'd0, 16'd2, 16'd3);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        I3,          12'h109, 32'h108,       I3,  32'h104,       32'h108,       12'h000, 5'd0, 16'd2, 16'd4);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I0,          12'h10A, 32'h10C,       I0,  32'h108,       32'h10C,       12'h10A, 5'd4, 16'd2, 16'd4);
        // StallD alone: D holds, F advances, E reloads from the held D
        vecs[10] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        I1,          12'h10B, 32'h110,       I0,  32'h108,       32'h10C,       12'h10B, 5'd1, 16'd3, 16'd4);
        vecs[11] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFC, I1,          12'h10C, 32'hFFFFFFFC,  I1,  32'h110,       32'h114,       12'h10C, 5'd1, 16'd3, 16'd4);
        // PC and PC+4 wrap modulo 2^32
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        I2,          12'h10D, 32'h0,         I2,  32'hFFFFFFFC,  32'h0,         12'h10D, 5'd2, 16'd3, 16'd4);

        for (int i = 0; i < 13; i++) begin
            StallF = vecs[i].stf; StallD = vecs[i].std;
            FlushD = vecs[i].fd;  FlushE = vecs[i].fe;
            PCSrcE = vecs[i].pcs; PCTargetE = vecs[i].tgt;
            InstrF = vecs[i].instrf; CtrlD = vecs[i].ctrld;
            sbq.push_back(vecs[i]);
            tick();
            if (sbq.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                exp_v = sbq.pop_front();
                chk($sformatf("v%0d_PCF", i),      PCF, exp_v.pcf);
                chk($sformatf("v%0d_InstrD", i),   InstrD, exp_v.instrd);
                chk($sformatf("v%0d_PCD", i),      PCD, exp_v.pcd);
                chk($sformatf("v%0d_PCPlus4D", i), PCPlus4D, exp_v.pcp4);
                chk($sformatf("v%0d_Rs1D", i),     {27'd0, Rs1D}, {27'd0, exp_v.instrd[19:15]});
                chk($sformatf("v%0d_Rs2D", i),     {27'd0, Rs2D}, {27'd0, exp_v.instrd[24:20]});
                chk($sformatf("v%0d_CtrlE", i),    {20'd0, CtrlE}, {20'd0, exp_v.ctrle});
                chk($sformatf("v%0d_RdE", i),      {27'd0, RdE}, {27'd0, exp_v.rde});
                chk($sformatf("v%0d_StallCnt", i), {16'd0, StallCount}, {16'd0, exp_v.sc});
                chk($sformatf("v%0d_FlushCnt", i), {16'd0, FlushCount}, {16'd0, exp_v.fc});
            end
        end

        // ID/EX load of operands, then forwarding without any clock edge
        idle();
        RD1D = 32'h11; RD2D = 32'h44; ImmExtD = 32'h55; CtrlD = 12'hABC; InstrF = I3;
        tick();
        chk("ex_PCE",     PCE, 32'hFFFF_FFFC);
        chk("ex_ImmExtE", ImmExtE, 32'h55);
        chk("ex_Rs1E",    {27'd0, Rs1E}, 32'd0);
        chk("ex_Rs2E",    {27'd0, Rs2E}, 32'd3);
        chk("ex_RdE",     {27'd0, RdE}, 32'd3);
        chk("ex_CtrlE",   {20'd0, CtrlE}, 32'hABC);

        fwds[0] = '{2'b00, 2'b00, 32'h22, 32'h33, 32'h11, 32'h44};
        fwds[1] = '{2'b01, 2'b01, 32'h22, 32'h33, 32'h33, 32'h33};
        fwds[2] = '{2'b10, 2'b10, 32'h22, 32'h33, 32'h22, 32'h22};
        fwds[3] = '{2'b11, 2'b11, 32'h22, 32'h33, 32'h11, 32'h44};
        fwds[4] = '{2'b10, 2'b01, 32'hCAFE0000, 32'h12345678, 32'hCAFE0000, 32'h12345678};
        fwds[5] = '{2'b01, 2'b10, 32'hCAFE0000, 32'h12345678, 32'h12345678, 32'hCAFE0000};
        for (int i = 0; i < 6; i++) begin
            ForwardAE = fwds[i].fa; ForwardBE = fwds[i].fb;
            ALUResultM = fwds[i].alum; ResultW = fwds[i].resw;
            #1;
            chk($sformatf("fwd%0d_SrcAE", i),   SrcAE, fwds[i].expa);
            chk($sformatf("fwd%0d_WrDataE", i), WriteDataE, fwds[i].expb);
        end

        // Counter saturation: stall and flush held from a fresh reset
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        for (int unsigned k = 0; k < 65534; k++) begin
            FlushD = k[0];
            tick();
        end
        chk("sat_StallCnt_FFFE", {16'd0, StallCount}, 32'hFFFE);
        chk("sat_FlushCnt_FFFE", {16'd0, FlushCount}, 32'hFFFE);
        for (int unsigned k = 0; k < 6; k++) begin
            FlushD = k[0];
            tick();
        end
        chk("sat_StallCnt_FFFF", {16'd0, StallCount}, 32'hFFFF);
        chk("sat_FlushCnt_FFFF", {16'd0, FlushCount}, 32'hFFFF);

        // Reset in the middle of a held stall carrying a redirect
        idle();
        RD1D = 32'h11; RD2D = 32'h44; CtrlD = 12'hFFF; InstrF = I3;
        tick();
        StallF = 1'b1; StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        tick();
        chk("mid_PCF", PCF, 32'h300);
        reset_n = 1'b0;
        tick();
        chk_cold("mrst");
        reset_n = 1'b1;
        idle();
        InstrF = I0;
        tick();
        chk("post_PCF",      PCF, 32'h4);
        chk("post_InstrD",   InstrD, I0);
        chk("post_StallCnt", {16'd0, StallCount}, 32'h0);
        chk("post_FlushCnt", {16'd0, FlushCount}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_front.md
PIPE_FRONT -- requirements
Module: pipe_front

Interface
- REQ-001 SHALL have one clock and one reset; reset is synchronous, active-low.
- REQ-002 clk  in  1  rising-edge clock; all state updates on this edge.
- REQ-003 reset_n  in  1  synchronous active-low reset.
- REQ-004 StallF, StallD, FlushD, FlushE  in  1 each  hazard controls from the hazard unit.
- REQ-005 ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- REQ-006 PCSrcE  in  1  redirect request from E; PCTargetE  in  32  redirect target.
- REQ-007 InstrF  in  32  fetched instruction at PCF.
- REQ-008 RD1D, RD2D, ImmExtD  in  32 each  decode-stage register reads and immediate; CtrlD  in  12  opaque decode control bundle.
- REQ-009 ALUResultM, ResultW  in  32 each  forwarding sources.
- REQ-010 PCF  out  32  fetch PC; InstrD, PCD, PCPlus4D  out  32 each  IF/ID register.
- REQ-011 Rs1D, Rs2D  out  5 each  = InstrD[19:15], InstrD[24:20], combinational.
- REQ-012 PCE, ImmExtE  out  32 each; Rs1E, Rs2E, RdE  out  5 each; CtrlE  out  12  ID/EX register.
- REQ-013 SrcAE, WriteDataE  out  32 each  forwarded operands.
- REQ-014 StallCount, FlushCount  out  16 each  saturating event counters.

Function
- REQ-015 PC register: next = PCSrcE ? PCTargetE : PCF+4 (mod 2^32, no overflow flag).
- REQ-016 PCF SHALL load next when StallF=0 or PCSrcE=1; PCSrcE overrides StallF; otherwise PCF holds.
- REQ-017 IF/ID priority: FlushD > StallD > load.
- REQ-018 IF/ID flush: InstrD <= 0x00000013 (NOP), PCD <= 0, PCPlus4D <= 0.
- REQ-019 IF/ID load: InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCF+4; stall holds all three.
- REQ-020 ID/EX: FlushE=1 loads bubble (all ID/EX outputs 0, incl. CtrlE, RdE); else loads PCD, ImmExtD, Rs1D, Rs2D, InstrD[11:7], CtrlD, RD1D, RD2D (RD1E/RD2E internal). ID/EX has no stall input.
- REQ-021 SrcAE: ForwardAE 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E (reserved); combinational, zero latency.
- REQ-022 WriteDataE: same mapping on ForwardBE with RD2E.
- REQ-023 Latency: one cycle per register (F->D, D->E); a stalled instruction remains in D for every stalled cycle.
- REQ-024 StallCount SHALL increment by 1 on each clock edge with reset_n=1 and StallD=1; saturates at 0xFFFF.
- REQ-025 FlushCount SHALL increment by 1 on each clock edge with reset_n=1 and (FlushD=1 or FlushE=1); one count per cycle even if both; saturates at 0xFFFF.
- REQ-026 Simultaneous StallD=1 and FlushE=1 (load-use): D holds, E gets bubble, F holds unless PCSrcE.
- REQ-027 Simultaneous FlushD and StallD: flush wins (REQ-017).

Reset
- REQ-028 On clk edge with reset_n=0: PCF=0, InstrD=0x00000013, PCD=0, PCPlus4D=0, all ID/EX outputs 0, both counters 0.
- REQ-029 Reset SHALL override every control input, including PCSrcE, in the same cycle.
- REQ-030 Reset asserted mid-stall or mid-flush SHALL leave no residual state; first post-reset cycle behaves as from cold.
- REQ-031 Combinational outputs (Rs1D, Rs2D, SrcAE, WriteDataE) follow register contents during reset.

Verification
- REQ-032 Reset release, no hazards, 3 cycles -> PCF 0x0,0x4,0x8,0xC; InstrD tracks InstrF one cycle late; counters 0.
- REQ-033 PCF=0x10, StallF=StallD=FlushE=1 for 1 cycle -> PCF stays 0x10, InstrD unchanged, CtrlE=0, RdE=0, StallCount=1, FlushCount=1.
- REQ-034 PCSrcE=1, PCTargetE=0x100, FlushD=FlushE=1, StallF=1 -> next PCF=0x100, InstrD=0x00000013, CtrlE=0.
- REQ-035 RD1E=0x11, ALUResultM=0x22, ResultW=0x33: ForwardAE 00/01/10/11 -> SrcAE 0x11/0x33/0x22/0x11; same for ForwardBE/WriteDataE.
- REQ-036 StallD=1 held 65,540 cycles -> StallCount reaches 0xFFFF and holds.
- REQ-037 reset_n=0 for one cycle during a held stall with PCSrcE=1 -> all state per REQ-028; counters 0.
